// File: rtl/base_receiver.sv
// Serial packet receiver: UART-style byte decoder feeding a SYNC/LEN/payload/CHK
// framer that buffers each packet and delivers it over a valid/ready stream only once CHK matches.
module base_receiver #(
  parameter int          CLKS_PER_BIT = 4,
  parameter logic [7:0]  SYNC         = 8'hA5,
  parameter int          MAX_LEN      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       rx,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       pkt_ok,
  output logic       pkt_err,
  output logic       busy
);

  localparam logic [7:0] CPB8  = 8'(CLKS_PER_BIT);
  localparam logic [7:0] HALF8 = 8'(CLKS_PER_BIT / 2);
  localparam logic [7:0] MAXL8 = 8'(MAX_LEN);
  localparam int         AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_t;
  typedef enum logic [2:0] {P_HUNT, P_LEN, P_PAYLOAD, P_CHECK, P_DRAIN} pstate_t;

  logic [1:0] sync_q;
  logic       rx_s;

  bstate_t    bstate_q, bstate_d;
  logic [7:0] bcnt_q, bcnt_d;
  logic [2:0] bitn_q, bitn_d;
  logic [7:0] shift_q, shift_d;
  logic       byte_stb, byte_ferr;

  pstate_t    pstate_q, pstate_d;
  logic [7:0] len_q, len_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] xor_q, xor_d;
  logic       ok_q, ok_d;
  logic       err_q, err_d;
  logic       ovalid_q, ovalid_d;
  logic       buf_we;
  logic [7:0] mem_q [0:(1<<AW)-1];

  assign rx_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '1;
      bstate_q <= B_IDLE;
      bcnt_q   <= '0;
      bitn_q   <= '0;
      shift_q  <= '0;
      pstate_q <= P_HUNT;
      len_q    <= '0;
      idx_q    <= '0;
      xor_q    <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], rx};
      bstate_q <= bstate_d;
      bcnt_q   <= bcnt_d;
      bitn_q   <= bitn_d;
      shift_q  <= shift_d;
      pstate_q <= pstate_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      xor_q    <= xor_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      ovalid_q <= ovalid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) mem_q[idx_q[AW-1:0]] <= shift_q;
  end

  // The counter restarts at 1 so the cycle that detected the edge counts toward the half-bit.
  always_comb begin
    bstate_d  = bstate_q;
    bcnt_d    = bcnt_q;
    bitn_d    = bitn_q;
    shift_d   = shift_q;
    byte_stb  = 1'b0;
    byte_ferr = 1'b0;
    case (bstate_q)
      B_IDLE: begin
        bcnt_d = 8'd1;
        bitn_d = '0;
        if (!rx_s) bstate_d = B_START;
      end
      B_START: begin
        if (bcnt_q == HALF8) begin
          bcnt_d   = 8'd1;
          bstate_d = rx_s ? B_IDLE : B_DATA;
        end else begin
          bcnt_d = bcnt_q + 8'd1;
        end
      end
      B_DATA: begin
        if (bcnt_q == CPB8) begin
          bcnt_d  = 8'd1;
          shift_d = {rx_s, shift_q[7:1]};
          if (bitn_q == 3'd7) bstate_d = B_STOP;
          else                bitn_d   = bitn_q + 3'd1;
        end else begin
          bcnt_d = bcnt_q + 8'd1;
        end
      end
      B_STOP: begin
        if (bcnt_q == CPB8) begin
          bstate_d  = B_IDLE;
          byte_stb  = rx_s;
          byte_ferr = !rx_s;
        end else begin
          bcnt_d = bcnt_q + 8'd1;
        end
      end
    endcase
    if (!enable) begin
      bstate_d  = B_IDLE;
      byte_stb  = 1'b0;
      byte_ferr = 1'b0;
    end
  end

  always_comb begin
    pstate_d = pstate_q;
    len_d    = len_q;
    idx_d    = idx_q;
    xor_d    = xor_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    ovalid_d = ovalid_q;
    buf_we   = 1'b0;
    case (pstate_q)
      P_HUNT: begin
        if (byte_stb && shift_q == SYNC) pstate_d = P_LEN;
      end
      P_LEN: begin
        if (byte_ferr) begin
          err_d    = 1'b1;
          pstate_d = P_HUNT;
        end else if (byte_stb) begin
          if (shift_q == 8'd0 || shift_q > MAXL8) begin
            err_d    = 1'b1;
            pstate_d = P_HUNT;
          end else begin
            len_d    = shift_q;
            xor_d    = shift_q;
            idx_d    = '0;
            pstate_d = P_PAYLOAD;
          end
        end
      end
      P_PAYLOAD: begin
        if (byte_ferr) begin
          err_d    = 1'b1;
          pstate_d = P_HUNT;
        end else if (byte_stb) begin
          buf_we = 1'b1;
          xor_d  = xor_q ^ shift_q;
          idx_d  = idx_q + 8'd1;
          if (idx_q == len_q - 8'd1) begin
            idx_d    = '0;
            pstate_d = P_CHECK;
          end
        end
      end
      P_CHECK: begin
        if (byte_ferr) begin
          err_d    = 1'b1;
          pstate_d = P_HUNT;
        end else if (byte_stb) begin
          if (shift_q == xor_q) begin
            ok_d     = 1'b1;
            pstate_d = P_DRAIN;
          end else begin
            err_d    = 1'b1;
            pstate_d = P_HUNT;
          end
        end
      end
      P_DRAIN: begin
        if (byte_stb) err_d = 1'b1;
        if (!ovalid_q) begin
          ovalid_d = 1'b1;
        end else if (out_ready) begin
          if (idx_q == len_q - 8'd1) begin
            ovalid_d = 1'b0;
            pstate_d = P_HUNT;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      default: pstate_d = P_HUNT;
    endcase
    if (!enable) begin
      pstate_d = P_HUNT;
      ovalid_d = 1'b0;
      ok_d     = 1'b0;
      err_d    = 1'b0;
      buf_we   = 1'b0;
    end
  end

  assign out_valid = ovalid_q;
  assign out_data  = ovalid_q ? mem_q[idx_q[AW-1:0]] : '0;
  assign out_last  = ovalid_q && (idx_q == len_q - 8'd1);
  assign pkt_ok    = ok_q;
  assign pkt_err   = err_q;
  assign busy      = (pstate_q != P_HUNT) || (bstate_q != B_IDLE);

endmodule

// File: tb/tb_base_receiver.sv
// Randomized and directed bench for base_receiver against a byte-stream packet parser model.
module tb_base_receiver;

  localparam int         CPB  = 4;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         MAXL = 16;

  logic       clk, rst, enable, rx, out_ready;
  logic [7:0] out_data;
  logic       out_valid, out_last, pkt_ok, pkt_err, busy;

  base_receiver #(.CLKS_PER_BIT(CPB), .SYNC(SYNC), .MAX_LEN(MAXL)) dut (
    .clk(clk), .rst(rst), .enable(enable), .rx(rx),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .pkt_ok(pkt_ok), .pkt_err(pkt_err), .busy(busy)
  );

  typedef struct {logic [7:0] data; logic last;} xfer_t;

  int n_cmp = 0, n_bad = 0;
  int exp_ok = 0, exp_err = 0, got_ok = 0, got_err = 0;
  int ready_mode = 0;
  xfer_t exp_q[$];
  int m_phase = 0;
  logic [7:0] m_len;
  logic [7:0] m_pay[$];

  initial begin clk = 0; forever #5 clk = ~clk; end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Packet rules applied byte by byte: HUNT / LEN / PAYLOAD / CHECK.
  task automatic model_byte(input logic [7:0] b, input logic ferr);
    logic [7:0] x;
    case (m_phase)
      0: if (!ferr && b == SYNC) m_phase = 1;
      1: begin
        if (ferr || b == 0 || int'(b) > MAXL) begin exp_err++; m_phase = 0; end
        else begin m_len = b; m_pay.delete(); m_phase = 2; end
      end
      2: begin
        if (ferr) begin exp_err++; m_phase = 0; end
        else begin
          m_pay.push_back(b);
          if (m_pay.size() == int'(m_len)) m_phase = 3;
        end
      end
      default: begin
        m_phase = 0;
        if (ferr) exp_err++;
        else begin
          x = m_len;
          foreach (m_pay[i]) x ^= m_pay[i];
          if (b == x) begin
            exp_ok++;
            foreach (m_pay[i]) exp_q.push_back('{m_pay[i], i == m_pay.size() - 1});
          end else exp_err++;
        end
      end
    endcase
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (CPB) tick();
    end
    rx = 1'b1;
    if (!stop) repeat (CPB) tick();
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic send(input logic [7:0] b, input logic stop = 1'b1);
    model_byte(b, !stop);
    send_byte(b, stop);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 2000) begin @(negedge clk); n++; end
    check_eq("valid_wait", out_valid, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    if (m_phase == 0) begin
      while (busy && n < 3000) begin @(negedge clk); n++; end
      check_eq("idle_wait", busy, 0);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_counts();
    check_eq("ok_count", got_ok, exp_ok);
    check_eq("err_count", got_err, exp_err);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  logic       pv = 0, pr = 0, pen = 0, prst = 1, pl = 0, ok_seen = 0;
  logic [7:0] pd = 0;
  always @(negedge clk) begin
    xfer_t e;
    if (pkt_ok) got_ok++;
    if (pkt_err) got_err++;
    if (pkt_ok || pkt_err) check_eq("ok_err_excl", pkt_ok && pkt_err, 0);
    if (ok_seen) check_eq("valid_after_ok", out_valid, 1);
    ok_seen = pkt_ok;
    if (pv && !pr && pen && !prst) begin
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_data", out_data, pd);
      check_eq("hold_last", out_last, pl);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check_eq("unexp_xfer", out_valid, 0);
      else begin
        e = exp_q.pop_front();
        check_eq("xfer_data", out_data, e.data);
        check_eq("xfer_last", out_last, e.last);
      end
    end
    pv = out_valid; pr = out_ready; pen = enable; prst = rst; pd = out_data; pl = out_last;
  end

  initial begin
    logic [7:0] len, x, chk;
    int ferr_at;
    rst = 1'b1; enable = 1'b1; rx = 1'b1; ready_mode = 0;
    repeat (3) tick();
    @(negedge clk);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_last", out_last, 0);
    check_eq("rst_ok", pkt_ok, 0);
    check_eq("rst_err", pkt_err, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_data", out_data, 0);
    tick();
    rst = 1'b0;
    repeat (4) tick();

    // good 3-byte packet, ready tied high
    send(SYNC); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    fork
      send(8'h03);
      begin
        wait_valid();
        check_eq("d32_b0", out_data, 8'h11); check_eq("d32_l0", out_last, 0);
        @(negedge clk);
        check_eq("d32_b1", out_data, 8'h22); check_eq("d32_l1", out_last, 0);
        @(negedge clk);
        check_eq("d32_b2", out_data, 8'h33); check_eq("d32_l2", out_last, 1);
      end
    join
    wait_idle(); check_counts();

    // bad checksum
    send(SYNC); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h00);
    wait_idle(); check_counts();

    // zero and oversize length
    send(SYNC); send(8'h00); wait_idle(); check_counts();
    send(SYNC); send(8'h11); wait_idle(); check_counts();

    // backpressure during drain
    ready_mode = 2;
    send(SYNC); send(8'h02); send(8'hAA); send(8'h55); send(8'hFD);
    wait_valid();
    repeat (10) begin
      @(negedge clk);
      check_eq("bp_data", out_data, 8'hAA);
    end
    ready_mode = 0;
    wait_idle(); check_counts();

    // byte arriving during drain is dropped with an error
    ready_mode = 2;
    send(SYNC); send(8'h01); send(8'h5A); send(8'h5B);
    wait_valid();
    send_byte(8'h3C, 1'b1);
    exp_err++;
    repeat (4) @(negedge clk);
    check_eq("drain_err_valid", out_valid, 1);
    check_eq("drain_err_data", out_data, 8'h5A);
    ready_mode = 0;
    wait_idle(); check_counts();

    // enable low mid-drain
    ready_mode = 2;
    send(SYNC); send(8'h02); send(8'h01); send(8'h02); send(8'h01);
    wait_valid();
    tick(); enable = 1'b0; tick(); enable = 1'b1;
    @(negedge clk);
    check_eq("en_valid", out_valid, 0);
    check_eq("en_busy", busy, 0);
    exp_q.delete();
    ready_mode = 0;
    repeat (5) tick();
    check_counts();

    // glitch, then framing error in payload
    tick(); rx = 1'b0; tick(); rx = 1'b1;
    repeat (20) tick();
    check_eq("glitch_busy", busy, 0);
    check_counts();
    send(SYNC); send(8'h03); send(8'h11); send(8'h22, 1'b0);
    wait_idle(); check_counts();

    // reset mid-payload, then a clean packet
    send(SYNC); send(8'h05); send(8'h01); send(8'h02);
    tick(); rst = 1'b1; tick(); rst = 1'b0;
    m_phase = 0;
    @(negedge clk);
    check_eq("mrst_valid", out_valid, 0);
    check_eq("mrst_last", out_last, 0);
    check_eq("mrst_ok", pkt_ok, 0);
    check_eq("mrst_err", pkt_err, 0);
    check_eq("mrst_busy", busy, 0);
    check_eq("mrst_data", out_data, 0);
    ready_mode = 1;
    send(SYNC); send(8'h02); send(8'hC3); send(8'h3C); send(8'hFD);
    wait_idle(); check_counts();

    // randomized packets
    for (int p = 0; p < 30; p++) begin
      ready_mode = 1;
      if ($urandom_range(0, 3) == 0) send(8'($urandom_range(0, 255)));
      send(SYNC);
      if ($urandom_range(0, 7) == 0) len = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAXL + 1, MAXL + 4));
      else len = 8'($urandom_range(1, MAXL));
      ferr_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, int'(len))) : -1;
      send(len);
      x = len;
      for (int i = 0; i < int'(len); i++) begin
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        x ^= b;
        send(b, i != ferr_at);
      end
      chk = x ^ (($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
      send(chk, ferr_at != int'(len));
      wait_idle();
      if (m_phase == 0) check_counts();
    end

    ready_mode = 0;
    wait_idle();
    check_counts();
    check_eq("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
